// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle for vga_fb_arbiter: timing counters, writer handshake, frame-buffer memory
// port and line-buffer write port. master = arbiter side, slave = environment side.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24
);
  logic [10:0]       hor_cnt;
  logic [9:0]        ver_cnt;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              lb_we;
  logic [6:0]        lb_addr;
  logic [DATA_W-1:0] lb_data;
  logic              fetch_err;
  logic [15:0]       wr_stall_cnt;

  modport master (
    input  hor_cnt, ver_cnt, wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, mem_addr, mem_rd, mem_wr, mem_wdata,
    output lb_we, lb_addr, lb_data, fetch_err, wr_stall_cnt
  );

  modport slave (
    output hor_cnt, ver_cnt, wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, mem_addr, mem_rd, mem_wr, mem_wdata,
    input  lb_we, lb_addr, lb_data, fetch_err, wr_stall_cnt
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: display line prefetch (priority, during h-blank) vs. req/ack writer.
// Optional feature macro VGA_ARB_STALL_STATS_EN enables the saturating writer stall counter.
module vga_fb_arbiter #(
  parameter int H_ACTIVE       = 800,
  parameter int V_ACTIVE       = 480,
  parameter int V_TOTAL        = 528,
  parameter int WORDS_PER_LINE = 100,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 24,
  parameter int RD_LAT         = 2
) (
  input logic             clock_pixel,
  input logic             reset_n,
  vga_fb_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [6:0] idx;
  } rd_tag_t;

  localparam logic [10:0]       H_TRIG     = 11'(H_ACTIVE);
  localparam logic [9:0]        V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]        V_VIS      = 10'(V_ACTIVE);
  localparam logic [6:0]        LAST_WORD  = 7'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(WORDS_PER_LINE);
  localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [6:0]        word_cnt_q, word_cnt_d;
  logic [2:0]        drain_cnt_q, drain_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wr_ack_q, wr_ack_d;
  logic              lb_we_q, lb_we_d;
  logic [6:0]        lb_addr_q, lb_addr_d;
  logic [DATA_W-1:0] lb_data_q, lb_data_d;
  logic              fetch_err_q, fetch_err_d;
  rd_tag_t           pipe_q [RD_LAT];
  rd_tag_t           pipe_d [RD_LAT];

  logic [9:0]        nl_s;
  logic              trigger_s;
  logic              grant_s;
  logic [6:0]        word_inc_s;

  // Next visible line and the fetch trigger decode.
  always_comb begin
    if (bus.ver_cnt == V_LAST) begin
      nl_s = 10'd0;
    end else begin
      nl_s = bus.ver_cnt + 10'd1;
    end
    trigger_s  = (bus.hor_cnt == H_TRIG) && (nl_s < V_VIS);
    word_inc_s = word_cnt_q + 7'd1;
  end

  // FSM next-state and registered memory-port outputs; fetch always beats the writer.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    word_cnt_d  = word_cnt_q;
    drain_cnt_d = drain_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    wr_ack_d    = 1'b0;
    grant_s     = 1'b0;
    fetch_err_d = fetch_err_q | (trigger_s && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (trigger_s) begin
          state_d    = ST_FETCH;
          word_cnt_d = 7'd0;
          mem_rd_d   = 1'b1;
          // Line 0 restarts the frame; otherwise base already points at the next line.
          if (nl_s == 10'd0) begin
            base_d     = {ADDR_W{1'b0}};
            mem_addr_d = {ADDR_W{1'b0}};
          end else begin
            mem_addr_d = base_q;
          end
        end else if (bus.wr_req) begin
          grant_s     = 1'b1;
          mem_wr_d    = 1'b1;
          wr_ack_d    = 1'b1;
          mem_addr_d  = bus.wr_addr;
          mem_wdata_d = bus.wr_data;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FETCH: begin
        if (word_cnt_q == LAST_WORD) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = 3'd0;
        end else begin
          word_cnt_d = word_inc_s;
          mem_rd_d   = 1'b1;
          mem_addr_d = base_q + {{(ADDR_W-7){1'b0}}, word_inc_s};
        end
      end

      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_IDLE;
          base_d  = base_q + LINE_STEP;
        end else begin
          drain_cnt_d = drain_cnt_q + 3'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read-return tag pipeline and line-buffer write capture.
  always_comb begin
    pipe_d[0].valid = mem_rd_q;
    pipe_d[0].idx   = word_cnt_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    lb_we_d = pipe_q[RD_LAT-1].valid;
    if (pipe_q[RD_LAT-1].valid) begin
      lb_addr_d = pipe_q[RD_LAT-1].idx;
      lb_data_d = bus.mem_rdata;
    end else begin
      lb_addr_d = lb_addr_q;
      lb_data_d = lb_data_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      base_q      <= {ADDR_W{1'b0}};
      word_cnt_q  <= 7'd0;
      drain_cnt_q <= 3'd0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= {DATA_W{1'b0}};
      wr_ack_q    <= 1'b0;
      lb_we_q     <= 1'b0;
      lb_addr_q   <= 7'd0;
      lb_data_q   <= {DATA_W{1'b0}};
      fetch_err_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '{valid: 1'b0, idx: 7'd0};
      end
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      word_cnt_q  <= word_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ack_q    <= wr_ack_d;
      lb_we_q     <= lb_we_d;
      lb_addr_q   <= lb_addr_d;
      lb_data_q   <= lb_data_d;
      fetch_err_q <= fetch_err_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

`ifdef VGA_ARB_STALL_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles the writer is requesting but not granted.
  always_comb begin
    if (bus.wr_req && !grant_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock_pixel or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.wr_stall_cnt = stall_cnt_q;
`else
  assign bus.wr_stall_cnt = 16'd0;
`endif

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.wr_ack    = wr_ack_q;
  assign bus.lb_we     = lb_we_q;
  assign bus.lb_addr   = lb_addr_q;
  assign bus.lb_data   = lb_data_q;
  assign bus.fetch_err = fetch_err_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: vector table of fetch triggers plus hand sequences
// for writer arbitration, back-to-back writes, fetch error and mid-fetch reset.
module tb_vga_fb_arbiter;
  localparam int RD_LAT = 2;
  localparam int WPL    = 100;
  localparam int LAST_K = WPL + RD_LAT + 1;

  typedef struct {
    logic [9:0]  ver;
    logic [10:0] hor;
    bit          fetch;
    logic [15:0] base;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [23:0] mem [0:65535];
  logic [23:0] rd_pipe [RD_LAT];

  vga_fb_arbiter_if #(.ADDR_W(16), .DATA_W(24)) bus ();

  vga_fb_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clock_pixel (clk),
    .reset_n     (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-latency memory model; data comes out RD_LAT cycles after MEM_RD is sampled.
  always @(posedge clk) begin
    rd_pipe[0] <= bus.mem_rd ? mem[bus.mem_addr] : 24'h0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one trigger vector and watch the full fetch window.
  task automatic run_fetch(input vec_t v);
    int rd_n, rd_bad, lb_n, lb_bad, idx;
    logic [15:0] a;
    rd_n = 0; rd_bad = 0; lb_n = 0; lb_bad = 0;
    bus.ver_cnt = v.ver;
    bus.hor_cnt = v.hor;
    for (int k = 1; k <= LAST_K + 2; k++) begin
      @(negedge clk);
      if (k == 1) bus.hor_cnt = 11'd0;
      if (bus.mem_rd) begin
        rd_n++;
        a = v.base + 16'(k - 1);
        if (k > WPL || bus.mem_addr !== a) rd_bad++;
      end
      if (bus.lb_we) begin
        lb_n++;
        idx = k - RD_LAT - 2;
        a = v.base + 16'(idx);
        if (idx < 0 || idx >= WPL || bus.lb_addr !== 7'(idx) || bus.lb_data !== mem[a]) lb_bad++;
      end
    end
    check($sformatf("rd_count v%0d", v.ver), rd_n, v.fetch ? WPL : 0);
    check($sformatf("rd_addr v%0d", v.ver), rd_bad, 0);
    check($sformatf("lb_count v%0d", v.ver), lb_n, v.fetch ? WPL : 0);
    check($sformatf("lb_data v%0d", v.ver), lb_bad, 0);
  endtask

  initial begin
    vec_t vecs [6];
    int   acks, bad, gap, first_k, rd_n, rd_bad;
    tests = 0;
    fails = 0;

    vecs[0] = '{ver: 10'd527, hor: 11'd800, fetch: 1'b1, base: 16'd0};
    vecs[1] = '{ver: 10'd0,   hor: 11'd800, fetch: 1'b1, base: 16'd100};
    vecs[2] = '{ver: 10'd1,   hor: 11'd800, fetch: 1'b1, base: 16'd200};
    vecs[3] = '{ver: 10'd479, hor: 11'd800, fetch: 1'b0, base: 16'd0};
    vecs[4] = '{ver: 10'd480, hor: 11'd800, fetch: 1'b0, base: 16'd0};
    vecs[5] = '{ver: 10'd100, hor: 11'd799, fetch: 1'b0, base: 16'd0};

    for (int i = 0; i < 65536; i++) mem[i] = 24'({i[15:0], i[7:0]} ^ 24'hC3A55A);

    rst_n       = 1'b1;
    bus.hor_cnt = 11'd0;
    bus.ver_cnt = 10'd0;
    bus.wr_req  = 1'b0;
    bus.wr_addr = 16'd0;
    bus.wr_data = 24'd0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset strobes", {bus.mem_rd, bus.mem_wr, bus.wr_ack, bus.lb_we, bus.fetch_err}, 5'd0);
    check("reset mem_addr", bus.mem_addr, 16'd0);
    check("reset mem_wdata", bus.mem_wdata, 24'd0);
    check("reset lb_addr", bus.lb_addr, 7'd0);
    check("reset lb_data", bus.lb_data, 24'd0);
    check("reset stall", bus.wr_stall_cnt, 16'd0);

    for (int i = 0; i < 6; i++) run_fetch(vecs[i]);

    // Writer held during trigger: base is 300 for ver 2 (line 3).
    bus.ver_cnt = 10'd2;
    bus.hor_cnt = 11'd800;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 16'hA000;
    bus.wr_data = 24'hABCDEF;
    acks = 0; bad = 0; first_k = 0; rd_n = 0; rd_bad = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) bus.hor_cnt = 11'd0;
      if (bus.mem_rd) begin
        rd_n++;
        if (bus.mem_addr !== 16'(300 + k - 1)) rd_bad++;
      end
      if (bus.wr_ack) begin
        acks++;
        if (first_k == 0) first_k = k;
        if (!bus.mem_wr || bus.mem_addr !== 16'hA000 || bus.mem_wdata !== 24'hABCDEF) bad++;
        bus.wr_req = 1'b0;
      end
    end
    check("arb first ack cycle", first_k, WPL + RD_LAT + 2);
    check("arb ack count", acks, 1);
    check("arb ack fields", bad, 0);
    check("arb rd count", rd_n, WPL);
    check("arb rd addr", rd_bad, 0);
    check("arb mem written", mem[16'hA000], 24'hABCDEF);
`ifdef VGA_ARB_STALL_STATS_EN
    check("stall count", bus.wr_stall_cnt, 16'(1 + WPL + RD_LAT));
`else
    check("stall count", bus.wr_stall_cnt, 16'd0);
`endif

    // Back-to-back writes during vertical blanking.
    bus.ver_cnt = 10'd500;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 16'hB000;
    bus.wr_data = 24'h100000;
    acks = 0; bad = 0; gap = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (bus.wr_ack) begin
        acks++;
        if (!bus.mem_wr || bus.mem_addr !== 16'(16'hB000 + acks - 1) ||
            bus.mem_wdata !== 24'(24'h100000 + acks - 1)) bad++;
      end else if (j <= 10) begin
        gap++;
      end
      if (j < 10) begin
        bus.wr_addr = 16'(16'hB000 + j);
        bus.wr_data = 24'(24'h100000 + j);
      end else begin
        bus.wr_req = 1'b0;
      end
    end
    check("b2b acks", acks, 10);
    check("b2b fields", bad, 0);
    check("b2b gaps", gap, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) if (mem[16'hB000 + i] !== 24'(24'h100000 + i)) bad++;
    check("b2b mem model", bad, 0);
`ifdef VGA_ARB_STALL_STATS_EN
    check("stall hold", bus.wr_stall_cnt, 16'(1 + WPL + RD_LAT));
`else
    check("stall hold", bus.wr_stall_cnt, 16'd0);
`endif

    // Second trigger mid-FETCH: flag sets, fetch from base 0 still completes.
    check("fetch_err clear", bus.fetch_err, 1'b0);
    bus.ver_cnt = 10'd527;
    bus.hor_cnt = 11'd800;
    rd_n = 0; rd_bad = 0;
    for (int k = 1; k <= LAST_K + 20; k++) begin
      @(negedge clk);
      if (k == 1 || k == 31) bus.hor_cnt = 11'd0;
      if (k == 30) bus.hor_cnt = 11'd800;
      if (bus.mem_rd) begin
        rd_n++;
        if (bus.mem_addr !== 16'(k - 1)) rd_bad++;
      end
    end
    check("err rd count", rd_n, WPL);
    check("err rd addr", rd_bad, 0);
    check("fetch_err sticky", bus.fetch_err, 1'b1);

    // Reset at word 50 of a fetch (base 100 for line 6).
    bus.ver_cnt = 10'd5;
    bus.hor_cnt = 11'd800;
    for (int k = 1; k <= 51; k++) begin
      @(negedge clk);
      if (k == 1) bus.hor_cnt = 11'd0;
    end
    check("pre-reset rd addr", bus.mem_addr, 16'd150);
    rst_n = 1'b0;
    #1;
    check("async strobes", {bus.mem_rd, bus.mem_wr, bus.wr_ack, bus.lb_we, bus.fetch_err}, 5'd0);
    check("async mem_addr", bus.mem_addr, 16'd0);
    check("async mem_wdata", bus.mem_wdata, 24'd0);
    check("async lb", {bus.lb_addr, bus.lb_data}, 31'd0);
    check("async stall", bus.wr_stall_cnt, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_n = 0;
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      if (bus.mem_rd || bus.lb_we) rd_n++;
    end
    check("no partial line", rd_n, 0);
    run_fetch('{ver: 10'd0, hor: 11'd800, fetch: 1'b1, base: 16'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Frame-buffer memory arbiter and line-fetch scheduler for the 800x480 VGA path. It shares one single-ported, fixed-latency pixel memory between two requesters: the display line prefetch, which has priority and is timed from the horizontal and vertical counters, and a drawing/CPU writer using a req/ack handshake. During horizontal blanking it fetches the next visible line into an external line buffer. It sits between the timing generator, the line buffer and the frame-buffer SRAM.

## Interface
- H_ACTIVE, 800: visible pixels per line; also the HOR_CNT value that triggers a fetch.
- V_ACTIVE, 480: visible lines.
- V_TOTAL, 528: total lines per frame.
- WORDS_PER_LINE, 100: memory words per line (8 px x 3-bit RGB per word).
- ADDR_W, 16: memory word-address width (48000 words).
- DATA_W, 24: memory data width.
- RD_LAT, 2: cycles from MEM_RD sampled to MEM_RDATA valid, range 1..4.
- CLOCK_PIXEL  in  1  pixel clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- HOR_CNT  in  11  horizontal counter from timing generator, 0..975.
- VER_CNT  in  10  vertical counter, 0..V_TOTAL-1.
- WR_REQ  in  1  writer request; held high until WR_ACK.
- WR_ADDR  in  ADDR_W  writer word address.
- WR_DATA  in  DATA_W  writer data.
- WR_ACK  out  1  one-cycle pulse in the cycle the write is driven to memory.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_RD  out  1  read strobe.
- MEM_WR  out  1  write strobe.
- MEM_WDATA  out  DATA_W  write data.
- MEM_RDATA  in  DATA_W  read data, valid RD_LAT cycles after MEM_RD.
- LB_WE  out  1  line-buffer write enable.
- LB_ADDR  out  7  line-buffer word index, 0..WORDS_PER_LINE-1.
- LB_DATA  out  DATA_W  line-buffer write data (registered MEM_RDATA).
- FETCH_ERR  out  1  sticky flag: a fetch trigger arrived while not IDLE.
- WR_STALL_CNT  out  16  writer stall counter (see Configuration).

## Operation
- Next line: NL = (VER_CNT == V_TOTAL-1) ? 0 : VER_CNT+1. A fetch trigger occurs when HOR_CNT == H_ACTIVE and NL < V_ACTIVE.
- Line base register: cleared when a trigger has NL == 0; otherwise advanced by WORDS_PER_LINE after each completed fetch. No multiplier.
- FSM states:
  - IDLE: a trigger goes to FETCH and clears the word counter. Otherwise, if WR_REQ, drive MEM_WR, MEM_ADDR=WR_ADDR, MEM_WDATA=WR_DATA and WR_ACK in the same registered cycle, then stay in IDLE.
  - FETCH: MEM_RD=1, MEM_ADDR=base+word counter, counter increments each cycle. After issuing word WORDS_PER_LINE-1, go to DRAIN.
  - DRAIN: hold for RD_LAT cycles until the last read returns, then go to IDLE. Writes are blocked.
- Read-return pipeline: an RD_LAT-deep shift register of {valid, index}. When the valid bit emerges, register LB_WE=1, LB_ADDR=index, LB_DATA=MEM_RDATA.
- Trigger and WR_REQ in the same cycle: the fetch wins and no WR_ACK is given. The writer keeps WR_REQ asserted.
- A trigger in FETCH or DRAIN sets FETCH_ERR, which is cleared only by reset. The in-progress fetch continues and the trigger is dropped.
- Vertical blanking lines (NL >= V_ACTIVE): no fetch; the writer may use every cycle.
- WR_REQ deasserting without an ack is legal; nothing is issued.

## Timing
- Reset: FSM=IDLE. MEM_RD, MEM_WR, WR_ACK, LB_WE and FETCH_ERR are 0. MEM_ADDR, MEM_WDATA, LB_ADDR, LB_DATA, the line base, the word counter, the pipeline and WR_STALL_CNT are 0.
- All outputs are registered.
- Trigger sampled at cycle T: MEM_RD is high on cycles T+1..T+WORDS_PER_LINE.
- First LB_WE at T+1+RD_LAT+1. Last LB_WE at T+WORDS_PER_LINE+RD_LAT+1.
- IDLE is re-entered at T+WORDS_PER_LINE+RD_LAT+1, which is 976-800=176 cycles of budget for defaults.
- Write latency: WR_REQ sampled high in IDLE -> WR_ACK/MEM_WR on the next edge. Maximum throughput is one write per cycle.
- RESET_N asserted mid-fetch: everything clears immediately. After release, no partial line completes; fetching resumes at the next trigger.

## Configuration
- VGA_ARB_STALL_STATS_EN defined: WR_STALL_CNT increments, saturating at 0xFFFF, on every cycle WR_REQ=1 and WR_ACK is not issued. It clears only on reset.
- Not defined: WR_STALL_CNT is tied to 0 and no counter logic exists.

## Test plan
- Reset, then VER_CNT=527, HOR_CNT=800 -> MEM_RD for 100 cycles on addresses 0..99, LB_WE x100 with LB_ADDR 0..99 and data matching the memory model. Latency follows the Timing section.
- Line sequence: VER_CNT=0 then 1 -> fetch bases 100 and 200. VER_CNT=479 and 480 -> no MEM_RD.
- WR_REQ held high during a fetch trigger -> no WR_ACK until the DRAIN exit cycle, then exactly one WR_ACK with the correct MEM_ADDR/MEM_WDATA. With the macro defined, WR_STALL_CNT = 1+100+RD_LAT.
- Back-to-back writes in vertical blanking: 10 requests -> 10 consecutive WR_ACK pulses, with the MEM_WR data written into the memory model.
- Force HOR_CNT=800 again mid-FETCH -> FETCH_ERR=1 and stays 1; the current fetch still completes 100 words.
- RESET_N low at word 50 of a fetch -> all outputs return to reset values asynchronously. After release with the counters restarted, the next fetch starts at base 0.
